// File: rtl/audio_core_pkg.sv
// Shared definitions for the audio codec core sequencer: register map,
// control bits, fifospace field layout and FSM state encoding.
package audio_core_pkg;

   localparam logic [1:0] ADDR_CTRL      = 2'd0;
   localparam logic [1:0] ADDR_FIFOSPACE = 2'd1;
   localparam logic [1:0] ADDR_LEFT      = 2'd2;
   localparam logic [1:0] ADDR_RIGHT     = 2'd3;

   localparam int CTRL_CR = 2;
   localparam int CTRL_CW = 3;

   localparam int FS_WSRC_LSB = 24;
   localparam int FS_WSLC_LSB = 16;
   localparam int FS_RARC_LSB = 8;
   localparam int FS_RALC_LSB = 0;

   typedef enum logic [3:0] {
      INIT_CLR, INIT_REL, IDLE, POLL, POLL_WAIT, DECIDE, GAP,
      WR_L, WR_R, RD_L, RD_L_WAIT, RD_R, RD_R_WAIT
   } state_t;

   function automatic logic [7:0] fs_field(input logic [31:0] fs, input int lsb);
      return fs[lsb +: 8];
   endfunction

endpackage

// File: rtl/audio_core_sched.sv
// Avalon-MM master that shares the audio codec core between a playback and a
// capture stream, polling fifospace before every left/right pair.
import audio_core_pkg::*;

module audio_core_sched #(
   parameter int DW       = 24,
   parameter int RD_LAT   = 1,
   parameter int POLL_GAP = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic [DW-1:0] play_l,
   input  logic [DW-1:0] play_r,
   input  logic          play_valid,
   output logic          play_ready,
   output logic [DW-1:0] cap_l,
   output logic [DW-1:0] cap_r,
   output logic          cap_valid,
   input  logic          cap_ready,
   output logic [1:0]    aud_address,
   output logic          aud_chipselect,
   output logic          aud_read,
   output logic          aud_write,
   output logic [31:0]   aud_writedata,
   input  logic [31:0]   aud_readdata,
   output logic          busy
);

   localparam int CNT_W = $clog2(RD_LAT + POLL_GAP + 2);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
   localparam logic [31:0] CTRL_CLEAR = (32'd1 << CTRL_CR) | (32'd1 << CTRL_CW);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      fs_q;
   logic             last_play;
   logic             play_ok, cap_ok, grant_play, grant_cap;

   always_comb begin
      play_ok    = play_valid && fs_field(fs_q, FS_WSLC_LSB) != 8'd0
                              && fs_field(fs_q, FS_WSRC_LSB) != 8'd0;
      cap_ok     = !cap_valid && fs_field(fs_q, FS_RALC_LSB) != 8'd0
                              && fs_field(fs_q, FS_RARC_LSB) != 8'd0;
      grant_play = play_ok && (!cap_ok || !last_play);
      grant_cap  = cap_ok && !grant_play;
   end

   // One down-counter serves init spacing, read latency and the poll gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT_CLR;
         cnt       <= CNT_W'(1);
         fs_q      <= '0;
         last_play <= 1'b0;
         cap_valid <= 1'b0;
         cap_l     <= '0;
         cap_r     <= '0;
      end else begin
         if (cap_valid && cap_ready) cap_valid <= 1'b0;
         case (state)
            INIT_CLR:  if (cnt == '0) state <= INIT_REL; else cnt <= cnt - 1'b1;
            INIT_REL:  state <= IDLE;
            IDLE:      if (enable) state <= POLL;
            POLL: begin
               cnt   <= LAT_LOAD;
               state <= POLL_WAIT;
            end
            POLL_WAIT: begin
               if (cnt == '0) begin
                  fs_q  <= aud_readdata;
                  state <= DECIDE;
               end else cnt <= cnt - 1'b1;
            end
            DECIDE: begin
               if (!enable) state <= IDLE;
               else if (grant_play) begin
                  last_play <= 1'b1;
                  state     <= WR_L;
               end else if (grant_cap) begin
                  last_play <= 1'b0;
                  state     <= RD_L;
               end else if (POLL_GAP == 0) state <= POLL;
               else begin
                  cnt   <= GAP_LOAD;
                  state <= GAP;
               end
            end
            GAP: begin
               if (cnt == '0) state <= enable ? POLL : IDLE;
               else cnt <= cnt - 1'b1;
            end
            WR_L:      state <= WR_R;
            WR_R:      state <= POLL;
            RD_L: begin
               cnt   <= LAT_LOAD;
               state <= RD_L_WAIT;
            end
            RD_L_WAIT: begin
               if (cnt == '0) begin
                  cap_l <= aud_readdata[DW-1:0];
                  state <= RD_R;
               end else cnt <= cnt - 1'b1;
            end
            RD_R: begin
               cnt   <= LAT_LOAD;
               state <= RD_R_WAIT;
            end
            RD_R_WAIT: begin
               if (cnt == '0) begin
                  cap_r     <= aud_readdata[DW-1:0];
                  cap_valid <= 1'b1;
                  state     <= POLL;
               end else cnt <= cnt - 1'b1;
            end
            default:   state <= INIT_CLR;
         endcase
      end
   end

   // Bus strobes decode from state; reset silences them in the same cycle.
   always_comb begin
      aud_address    = ADDR_CTRL;
      aud_chipselect = 1'b0;
      aud_read       = 1'b0;
      aud_write      = 1'b0;
      aud_writedata  = '0;
      play_ready     = 1'b0;
      case (state)
         INIT_CLR: begin
            aud_chipselect = (cnt != '0);
            aud_write      = (cnt != '0);
            aud_writedata  = CTRL_CLEAR;
         end
         INIT_REL: begin
            aud_chipselect = 1'b1;
            aud_write      = 1'b1;
         end
         POLL: begin
            aud_address    = ADDR_FIFOSPACE;
            aud_chipselect = 1'b1;
            aud_read       = 1'b1;
         end
         WR_L: begin
            aud_address    = ADDR_LEFT;
            aud_chipselect = 1'b1;
            aud_write      = 1'b1;
            aud_writedata  = 32'(signed'(play_l));
         end
         WR_R: begin
            aud_address    = ADDR_RIGHT;
            aud_chipselect = 1'b1;
            aud_write      = 1'b1;
            aud_writedata  = 32'(signed'(play_r));
            play_ready     = 1'b1;
         end
         RD_L: begin
            aud_address    = ADDR_LEFT;
            aud_chipselect = 1'b1;
            aud_read       = 1'b1;
         end
         RD_R: begin
            aud_address    = ADDR_RIGHT;
            aud_chipselect = 1'b1;
            aud_read       = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         aud_address    = ADDR_CTRL;
         aud_chipselect = 1'b0;
         aud_read       = 1'b0;
         aud_write      = 1'b0;
         aud_writedata  = '0;
         play_ready     = 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_audio_core_sched.sv
// Directed bench for audio_core_sched with a small behavioural codec core.
module tb_audio_core_sched;

   localparam int DW = 24;

   typedef struct {
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      int          c;
   } acc_t;

   logic          clk = 1'b0;
   logic          reset, enable;
   logic [DW-1:0] play_l, play_r, cap_l, cap_r;
   logic          play_valid, play_ready, cap_valid, cap_ready;
   logic [1:0]    aud_address;
   logic          aud_chipselect, aud_read, aud_write, busy;
   logic [31:0]   aud_writedata, aud_readdata;

   logic [31:0]   fs_val, rd_l_val, rd_r_val;
   acc_t          aq[$], dq[$];
   int            pc[$];
   int            cyc = 0, pr_cnt = 0, checks = 0, passes = 0, fails = 0;
   logic          prev_cs = 1'b0;
   logic [1:0]    prev_a = 2'd0;
   logic [2:0]    exp_code [8];

   audio_core_sched #(.DW(DW), .RD_LAT(1), .POLL_GAP(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .play_l(play_l), .play_r(play_r), .play_valid(play_valid), .play_ready(play_ready),
      .cap_l(cap_l), .cap_r(cap_r), .cap_valid(cap_valid), .cap_ready(cap_ready),
      .aud_address(aud_address), .aud_chipselect(aud_chipselect), .aud_read(aud_read),
      .aud_write(aud_write), .aud_writedata(aud_writedata), .aud_readdata(aud_readdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      check(tag, busy, 1'b0);
   endtask

   // Codec core model: one-cycle read latency.
   always @(posedge clk)
      if (aud_chipselect && aud_read)
         aud_readdata <= (aud_address == 2'd1) ? fs_val :
                         (aud_address == 2'd2) ? rd_l_val : rd_r_val;

   // Bus monitor: logs every access and enforces the strobe rules.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (aud_chipselect) begin
         check("strobe_onehot", aud_read ^ aud_write, 1'b1);
         if (prev_cs) check("b2b_same_reg", prev_a != aud_address, 1'b1);
         aq.push_back('{aud_write, aud_address, aud_writedata, cyc});
         if (aud_address >= 2'd2) dq.push_back('{aud_write, aud_address, aud_writedata, cyc});
      end
      prev_cs <= aud_chipselect;
      prev_a  <= aud_address;
      if (play_ready) pr_cnt <= pr_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = 1'b0; play_valid = 1'b0; cap_ready = 1'b0;
      play_l = '0; play_r = '0; aud_readdata = '0;
      fs_val = '0; rd_l_val = '0; rd_r_val = '0;
      repeat (3) @(negedge clk);
      check("rst_write", aud_write, 1'b0);
      check("rst_read", aud_read, 1'b0);
      check("rst_cs", aud_chipselect, 1'b0);
      check("rst_addr", aud_address, 2'd0);
      check("rst_wdata", aud_writedata, 32'h0);
      check("rst_play_ready", play_ready, 1'b0);
      check("rst_cap_valid", cap_valid, 1'b0);
      check("rst_cap_l", cap_l, 24'h0);
      check("rst_cap_r", cap_r, 24'h0);
      check("rst_busy", busy, 1'b1);

      // Init sequence: clear FIFOs, then interrupts off, then idle.
      aq.delete(); dq.delete();
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("init_count", aq.size(), 2);
      check("init0_write", aq[0].w, 1'b1);
      check("init0_addr", aq[0].a, 2'd0);
      check("init0_data", aq[0].d, 32'h0000000C);
      check("init1_addr", aq[1].a, 2'd0);
      check("init1_data", aq[1].d, 32'h00000000);
      check("init_spacing", aq[1].c - aq[0].c, 2);
      check("idle_busy", busy, 1'b0);

      // Playback pair with sign extension.
      aq.delete(); dq.delete(); pr_cnt = 0;
      fs_val = 32'h01010000; play_l = 24'h7FFFFF; play_r = 24'h800000;
      play_valid = 1'b1; enable = 1'b1;
      for (int i = 0; i < 50 && !play_ready; i++) @(negedge clk);
      check("play_ready_seen", play_ready, 1'b1);
      play_valid = 1'b0; enable = 1'b0;
      wait_idle("play_idle");
      check("play_count", dq.size(), 2);
      check("play_l_write", dq[0].w, 1'b1);
      check("play_l_addr", dq[0].a, 2'd2);
      check("play_l_data", dq[0].d, 32'h007FFFFF);
      check("play_r_addr", dq[1].a, 2'd3);
      check("play_r_data", dq[1].d, 32'hFF800000);
      check("play_ready_pulses", pr_cnt, 1);

      // Capture pair, held until accepted.
      aq.delete(); dq.delete();
      fs_val = 32'h00000101; rd_l_val = 32'h00123456; rd_r_val = 32'h55ABCDEF;
      enable = 1'b1;
      for (int i = 0; i < 50 && !cap_valid; i++) @(negedge clk);
      check("cap_valid_set", cap_valid, 1'b1);
      check("cap_l", cap_l, 24'h123456);
      check("cap_r", cap_r, 24'hABCDEF);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      check("cap_valid_held", cap_valid, 1'b1);
      check("cap_r_stable", cap_r, 24'hABCDEF);
      check("cap_reads", dq.size(), 2);
      check("cap_rd_l", {dq[0].w, dq[0].a}, 3'b010);
      check("cap_rd_r", {dq[1].w, dq[1].a}, 3'b011);
      wait_idle("cap_idle");
      cap_ready = 1'b1;
      @(negedge clk);
      cap_ready = 1'b0;
      check("cap_valid_clear", cap_valid, 1'b0);

      // Both eligible: round-robin play, cap, play, cap.
      aq.delete(); dq.delete();
      fs_val = 32'h01010101; play_l = 24'h000001; play_r = 24'h000002;
      play_valid = 1'b1; cap_ready = 1'b1; enable = 1'b1;
      for (int i = 0; i < 300 && dq.size() < 8; i++) @(negedge clk);
      enable = 1'b0;
      wait_idle("rr_idle");
      play_valid = 1'b0; cap_ready = 1'b0;
      check("rr_count", dq.size() >= 8, 1'b1);
      exp_code = '{3'b110, 3'b111, 3'b010, 3'b011, 3'b110, 3'b111, 3'b010, 3'b011};
      for (int i = 0; i < 8; i++) check($sformatf("rr_seq%0d", i), {dq[i].w, dq[i].a}, exp_code[i]);

      // Right-channel DAC full: no data writes, polls spaced by the gap.
      aq.delete(); dq.delete();
      fs_val = 32'h00050000; play_valid = 1'b1; enable = 1'b1;
      repeat (40) @(negedge clk);
      enable = 1'b0;
      wait_idle("gap_idle");
      play_valid = 1'b0;
      foreach (aq[i]) if (aq[i].a == 2'd1 && !aq[i].w) pc.push_back(aq[i].c);
      check("gap_no_data", dq.size(), 0);
      check("gap_poll_count", pc.size() >= 4, 1'b1);
      check("gap_spacing0", pc[1] - pc[0], 7);
      check("gap_spacing1", pc[2] - pc[1], 7);

      // Reset in WR_R with a capture pending.
      aq.delete(); dq.delete();
      fs_val = 32'h01010101; rd_l_val = 32'h00111111; rd_r_val = 32'h00222222;
      cap_ready = 1'b0; enable = 1'b1;
      for (int i = 0; i < 50 && !cap_valid; i++) @(negedge clk);
      check("rst_mid_cap_pending", cap_valid, 1'b1);
      play_l = 24'h0ABCDE; play_r = 24'h054321; play_valid = 1'b1;
      for (int i = 0; i < 50 && !play_ready; i++) @(negedge clk);
      check("rst_mid_in_wr_r", aud_write, 1'b1);
      check("rst_mid_wr_r_addr", aud_address, 2'd3);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_write_low", aud_write, 1'b0);
      check("rst_mid_cap_cleared", cap_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b1);
      enable = 1'b0; play_valid = 1'b0;
      aq.delete();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_restart_count", aq.size() >= 1, 1'b1);
      check("rst_mid_restart_addr", aq[0].a, 2'd0);
      check("rst_mid_restart_data", aq[0].d, 32'h0000000C);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
